// File: rtl/shift_mix_cols.sv
// Column-serial AES ShiftRows + MixColumns: one shared MixColumns datapath, one column per clock.
// Optional final-round bypass (ShiftRows only) when MIX_LAST_ROUND_EN is defined.
module shift_mix_cols (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] state,
`ifdef MIX_LAST_ROUND_EN
    input  logic         last,
`endif
    output logic         ready,
    output logic [127:0] state_out,
    output logic         done
);

    // state   | meaning
    // S_IDLE  | waiting for start, ready=1
    // S_COL   | mixing column r_col_cnt of r_w into r_acc
    // S_DONE  | done pulse cycle, ready=1, may accept next block
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COL  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t           r_fsm;
    fsm_t           w_fsm_nxt;
    logic [1:0]     r_col_cnt;
    logic [127:0]   r_w;
    logic [127:0]   r_acc;
    logic [127:0]   r_state_out;
    logic           r_done;

    logic           w_accept;
    logic           w_last_col;
    logic [127:0]   w_shifted;
    logic [31:0]    w_col_in;
    logic [31:0]    w_col_mix;
    logic [31:0]    w_col_res;
    logic [127:0]   w_acc_nxt;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b3, b2, b1, b0};
    endfunction

    assign ready      = (r_fsm == S_IDLE) || (r_fsm == S_DONE);
    assign w_accept   = start && ready;
    assign w_last_col = (r_fsm == S_COL) && (r_col_cnt == 2'd3);

    // ShiftRows folded into the load: row r of column c comes from column (c+r) mod 4
    always_comb begin
        w_shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shifted[8*(4*c+r) +: 8] = state[8*(4*((c+r)%4)+r) +: 8];
            end
        end
    end

    assign w_col_in  = r_w[32*r_col_cnt +: 32];
    assign w_col_mix = mix_col(w_col_in);

`ifdef MIX_LAST_ROUND_EN
    logic r_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_last <= last;
        end
    end

    assign w_col_res = r_last ? w_col_in : w_col_mix;
`else
    assign w_col_res = w_col_mix;
`endif

    always_comb begin
        w_acc_nxt = r_acc;
        w_acc_nxt[32*r_col_cnt +: 32] = w_col_res;
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            S_IDLE: if (start) w_fsm_nxt = S_COL;
            S_COL:  if (r_col_cnt == 2'd3) w_fsm_nxt = S_DONE;
            S_DONE: w_fsm_nxt = start ? S_COL : S_IDLE;
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_cnt <= 2'd0;
            r_w       <= '0;
        end else if (w_accept) begin
            r_col_cnt <= 2'd0;
            r_w       <= w_shifted;
        end else if (r_fsm == S_COL) begin
            r_col_cnt <= r_col_cnt + 2'd1;
        end
    end

    // Column 3 goes straight from the mixer into state_out on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_state_out <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_last_col;
            if (r_fsm == S_COL) begin
                r_acc <= w_acc_nxt;
            end
            if (w_last_col) begin
                r_state_out <= w_acc_nxt;
            end
        end
    end

    assign state_out = r_state_out;
    assign done      = r_done;

endmodule

// File: tb/tb_shift_mix_cols.sv
// Randomized self-checking bench for shift_mix_cols against a byte-array AES round model.
module tb_shift_mix_cols;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] state;
    logic         last_i;
    logic         ready;
    logic [127:0] state_out;
    logic         done;

    int n_chk = 0;
    int n_bad = 0;

    shift_mix_cols dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .state     (state),
`ifdef MIX_LAST_ROUND_EN
        .last      (last_i),
`endif
        .ready     (ready),
        .state_out (state_out),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input bit lst);
        logic [7:0] in_b [16];
        logic [7:0] sh   [16];
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [127:0] res;
        coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
        for (int i = 0; i < 16; i++) in_b[i] = s[8*i +: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sh[4*c+r] = in_b[4*((c+r)%4)+r];
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (lst) begin
                    acc = sh[4*c+r];
                end else begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++)
                        acc = acc ^ gmul(coef[(j - r + 4) % 4], sh[4*c+j]);
                end
                res[8*(4*c+r) +: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Launch one block from an idle/done DUT; scrambles `state` while busy.
    task automatic run_block(input logic [127:0] vec, input bit lst, input string tag,
                             output logic [127:0] res);
        int  n;
        bit  seen;
        logic [127:0] expv;
        expv = ref_round(vec, lst);
        @(negedge clk);
        state  = vec;
        last_i = lst;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        state  = rand128();
        last_i = ~lst;
        n = 1;
        chk({tag, "_ready_busy"}, 128'(ready), 128'd0);
        seen = 1'b0;
        while (!seen && n < 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                state = rand128();
                n++;
            end
        end
        chk({tag, "_latency"}, 128'(n), 128'd5);
        chk({tag, "_result"}, state_out, expv);
        res = expv;
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 128'(done), 128'd0);
    endtask

    logic [127:0] fips_in;
    logic [127:0] res;
    logic [127:0] vecs [3];
    logic [127:0] held;
    bit           seen_done;

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        state  = '0;
        last_i = 1'b0;
        fips_in = 128'h3052411ee55db4b8f198bfe0ae1127d4;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_out", state_out, 128'd0);

        @(negedge clk);
        rst = 1'b1;
        seen_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        chk("idle_no_done", 128'(seen_done), 128'd0);

        run_block(fips_in, 1'b0, "fips", res);
        chk("fips_known", res, 128'h4c2606287ad3f8489a19cbe0e5816604);

`ifdef MIX_LAST_ROUND_EN
        run_block(fips_in, 1'b1, "last", res);
        chk("last_known", res, 128'he598271ef11141b8ae52b4e0305dbfd4);
`endif

        for (int k = 0; k < 6; k++) begin
`ifdef MIX_LAST_ROUND_EN
            run_block(rand128(), bit'($urandom_range(0, 1)), "rand", res);
`else
            run_block(rand128(), 1'b0, "rand", res);
`endif
        end

        // back-to-back: start high for 12 edges, accepts expected at edges 0, 5, 10
        for (int v = 0; v < 3; v++) vecs[v] = rand128();
        last_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = (i < 12);
            if (i % 5 == 0 && i < 15) state = vecs[i/5];
            else state = rand128();
            chk("b2b_ready", 128'(ready), ((i >= 15) || (i % 5 == 0)) ? 128'd1 : 128'd0);
            @(posedge clk);
            #1;
            chk("b2b_done", 128'(done), ((i % 5 == 4) && (i < 15)) ? 128'd1 : 128'd0);
            if ((i % 5 == 4) && (i < 15))
                chk("b2b_result", state_out, ref_round(vecs[i/5], 1'b0));
        end
        start = 1'b0;

        // reset on the E2 edge of a block in flight
        @(negedge clk);
        state = rand128();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready", 128'(ready), 128'd1);
        chk("midrst_done", 128'(done), 128'd0);
        chk("midrst_out", state_out, 128'd0);
        seen_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        chk("midrst_no_done", 128'(seen_done), 128'd0);
        chk("midrst_out_held", state_out, 128'd0);
        run_block(rand128(), 1'b0, "post_rst", res);

        // output hold with state churning and start low
        held = res;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            state = rand128();
            @(posedge clk);
            #1;
            chk("hold_out", state_out, held);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
